// File: rtl/icache_resp_pkg.sv
// Shared types and constants for the instruction-cache responder.
// Purpose : index/tag/offset widths, line layout, FSM state encoding,
//           AXI burst/size/len constants and the kseg1 (uncached) decode.
// Ports   : none (package).
// Optional feature macro used by the top: ICACHE_PERF_CNT_EN.
package icache_resp_pkg;

  localparam int ICACHE_INDEX_W = 8;
  localparam int ICACHE_TAG_W   = 20;
  localparam int ICACHE_OFF_W   = 4;
  localparam int ICACHE_SETS    = 1 << ICACHE_INDEX_W;
  localparam int LINE_WORDS     = 4;
  localparam int DATA_W         = 32;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
  localparam logic [7:0] AXI_LEN_LINE   = 8'd3;
  localparam logic [7:0] AXI_LEN_WORD   = 8'd0;

  typedef logic [ICACHE_TAG_W-1:0]             tag_t;
  typedef logic [ICACHE_INDEX_W-1:0]           index_t;
  typedef logic [ICACHE_OFF_W-1:0]             offset_t;
  typedef logic [LINE_WORDS-1:0][DATA_W-1:0]   line_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS,
    ST_REFILL,
    ST_RESP
  } state_e;

  // kseg1 (0xA000_0000..0xBFFF_FFFF) fetches bypass the cache.
  function automatic logic is_uncached(input tag_t tag);
    return tag[19:17] == 3'b101;
  endfunction

endpackage

// File: rtl/icache_resp_if.sv
// Bus bundle between the IF stage / AXI crossbar and the ICache responder.
// Purpose : groups the instruction request/response handshake and the
//           AXI AR/R channel signals.
// Modports: slave  - the cache (takes requests, drives AXI master outputs)
//           master - the environment (IF stage + AXI slave side)
interface icache_resp_if;
  import icache_resp_pkg::*;

  // instruction request / response
  logic                inst_valid;
  logic                inst_op;
  index_t              inst_index;
  tag_t                inst_tag;
  offset_t             inst_offset;
  logic                inst_addr_ok;
  logic                inst_data_ok;
  logic [DATA_W-1:0]   inst_rdata;

  // AXI read address channel
  logic [3:0]          arid;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  // AXI read data channel
  logic [3:0]          rid;
  logic [DATA_W-1:0]   rdata;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  inst_valid, inst_op, inst_index, inst_tag, inst_offset,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rlast, rvalid,
    output rready
  );

  modport master (
    output inst_valid, inst_op, inst_index, inst_tag, inst_offset,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/icache_line_ram.sv
// Line storage for the direct-mapped ICache: 256 x {valid, tag, 128-bit data}.
// Purpose : synchronous read, single write port; valid bits clear
//           asynchronously on reset, tag/data arrays are not reset.
// Ports   : clk, reset        - clock, async active-high reset
//           rd_en, rd_idx     - read request (result next cycle)
//           rd_valid/tag/data - registered read result
//           we, wr_idx, wr_tag, wr_data - line write (sets valid)
module icache_line_ram
  import icache_resp_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   rd_en,
  input  index_t rd_idx,
  output logic   rd_valid,
  output tag_t   rd_tag,
  output line_t  rd_data,
  input  logic   we,
  input  index_t wr_idx,
  input  tag_t   wr_tag,
  input  line_t  wr_data
);

  logic [ICACHE_SETS-1:0] valid_q;
  tag_t                   tag_mem  [ICACHE_SETS];
  line_t                  data_mem [ICACHE_SETS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (we)
        valid_q[wr_idx] <= 1'b1;
      if (rd_en)
        rd_valid <= valid_q[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_tag  <= tag_mem[rd_idx];
      rd_data <= data_mem[rd_idx];
    end
  end

endmodule

// File: rtl/icache_resp.sv
// Instruction-side ICache responder (direct-mapped, read-only, 256 x 16 B).
// Purpose : accepts IF-stage fetches, answers hits one cycle after accept
//           (back-to-back), refills misses over AXI (4-beat INCR) and
//           fetches kseg1 addresses uncached with a single-beat read.
// Ports   : clk, reset (async, active-high)
//           bus      - icache_resp_if.slave (inst req/resp + AXI AR/R)
//           hit_cnt, miss_cnt - only when ICACHE_PERF_CNT_EN is defined
// Macro   : ICACHE_PERF_CNT_EN adds the hit/miss performance counters.
module icache_resp
  import icache_resp_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd0
)(
  input  logic         clk,
  input  logic         reset,
  icache_resp_if.slave bus
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
`endif
);

  state_e              state;
  logic                ready_q;
  logic                arvalid_q;
  logic                rready_q;
  logic [1:0]          beat_q;
  tag_t                req_tag_p0;
  index_t              req_index_p0;
  offset_t             req_offset_p0;
  line_t               line_buf_q;
  line_t               fill_line;
  logic [DATA_W-1:0]   crit_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                ram_rd_valid;
  tag_t                ram_rd_tag;
  line_t               ram_rd_data;

  logic                uncached;
  logic                hit;
  logic                accept;
  logic                beat_ok;
  logic                fill_done;
  logic [DATA_W-1:0]   hit_word;

  assign uncached  = is_uncached(req_tag_p0);
  assign hit       = (state == ST_LOOKUP) && !uncached && ram_rd_valid &&
                     (ram_rd_tag == req_tag_p0);
  assign hit_word  = ram_rd_data[req_offset_p0[3:2]];
  // IDLE readiness is registered so addr_ok stays low through reset.
  assign accept    = bus.inst_valid && bus.inst_addr_ok;
  // Beats tagged for another master are consumed but not counted.
  assign beat_ok   = (state == ST_REFILL) && rready_q && bus.rvalid &&
                     (bus.rid == AXI_ID);
  assign fill_done = beat_ok && bus.rlast;

  always_comb begin
    fill_line         = line_buf_q;
    fill_line[beat_q] = bus.rdata;
  end

  icache_line_ram u_ram (
    .clk      (clk),
    .reset    (reset),
    .rd_en    (accept),
    .rd_idx   (bus.inst_index),
    .rd_valid (ram_rd_valid),
    .rd_tag   (ram_rd_tag),
    .rd_data  (ram_rd_data),
    .we       (fill_done && !uncached),
    .wr_idx   (req_index_p0),
    .wr_tag   (req_tag_p0),
    .wr_data  (fill_line)
  );

  assign bus.inst_addr_ok = ready_q || hit;
  assign bus.inst_data_ok = hit || (state == ST_RESP);
  assign bus.inst_rdata   = hit ? hit_word :
                            (state == ST_RESP) ? crit_q : rdata_q;

  assign bus.arid    = AXI_ID;
  assign bus.araddr  = uncached ? {3'b000, req_tag_p0[16:0], req_index_p0, req_offset_p0}
                                : {3'b000, req_tag_p0[16:0], req_index_p0, 4'h0};
  assign bus.arlen   = uncached ? AXI_LEN_WORD : AXI_LEN_LINE;
  assign bus.arsize  = AXI_SIZE_WORD;
  assign bus.arburst = AXI_BURST_INCR;
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = rready_q;

  // Request capture: address fields for the lookup stage.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_tag_p0    <= bus.inst_tag;
      req_index_p0  <= bus.inst_index;
      req_offset_p0 <= bus.inst_offset;
    end
  end

  // Refill datapath: line assembly and critical-word capture.
  always_ff @(posedge clk) begin
    if (beat_ok) begin
      line_buf_q <= fill_line;
      if (uncached || (beat_q == req_offset_p0[3:2]))
        crit_q <= bus.rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      ready_q   <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      beat_q    <= 2'd0;
      rdata_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state   <= ST_LOOKUP;
            ready_q <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_LOOKUP: begin
          if (hit) begin
            rdata_q <= hit_word;
            if (!accept) begin
              state   <= ST_IDLE;
              ready_q <= 1'b1;
            end
          end else begin
            state     <= ST_MISS;
            arvalid_q <= 1'b1;
          end
        end
        ST_MISS: begin
          if (bus.arready) begin
            state     <= ST_REFILL;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat_q    <= 2'd0;
          end
        end
        ST_REFILL: begin
          if (beat_ok) begin
            beat_q <= beat_q + 2'd1;
            if (bus.rlast) begin
              state    <= ST_RESP;
              rready_q <= 1'b0;
            end
          end
        end
        ST_RESP: begin
          rdata_q <= crit_q;
          state   <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit)
        hit_cnt <= hit_cnt + 32'd1;
      if ((state == ST_LOOKUP) && !hit && !uncached)
        miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_resp.sv
// Testbench for icache_resp: scoreboard of expected fetch data and AR
// beats, a reactive AXI read slave backed by a sparse word memory.
// Build with ICACHE_PERF_CNT_EN defined to also exercise the counters.
module tb_icache_resp;

  logic clk;
  logic reset;
  int   cyc;
  int   n_tests;
  int   n_fail;

  icache_resp_if bus();

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache_resp dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  logic [31:0] exp_araddr[$];
  logic [7:0]  exp_arlen[$];
  int          okq[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] last_exp;
  int          beats;
  int          rlast_cyc;
  bit          bad_rid_en;
  bit          early_last_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  // AXI read slave: one AR at a time, beats back-to-back.
  initial begin : axi_slave
    logic [31:0] addr;
    logic [7:0]  len;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rid     = 4'd0;
    bus.rdata   = '0;
    bus.rlast   = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.arvalid && !reset) begin
        addr = bus.araddr;
        len  = bus.arlen;
        bus.arready = 1'b1;
        @(posedge clk); #1;
        bus.arready = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
          if (bad_rid_en && i == 1) begin
            bus.rvalid = 1'b1; bus.rid = 4'hF; bus.rdata = 32'hDEAD_BEEF; bus.rlast = 1'b1;
            @(posedge clk); #1;
            if (reset) break;
          end
          bus.rvalid = 1'b1;
          bus.rid    = 4'd0;
          bus.rdata  = mem_word(addr + 32'(4 * i));
          bus.rlast  = (i == int'(len)) || (early_last_en && i == 1);
          @(posedge clk); #1;
          if (reset || bus.rlast) break;
        end
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rid    = 4'd0;
      end
    end
  end

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.inst_data_ok) begin
        okq.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("spurious_data_ok", 32'd1, 32'd0);
        end else begin
          last_exp = exp_q.pop_front();
          check("rdata", bus.inst_rdata, last_exp);
        end
      end
      if (bus.arvalid && bus.arready) begin
        if (exp_araddr.size() == 0) begin
          check("spurious_ar", bus.araddr, 32'hFFFF_FFFF);
        end else begin
          check("araddr", bus.araddr, exp_araddr.pop_front());
          check("arlen", {24'd0, bus.arlen}, {24'd0, exp_arlen.pop_front()});
          check("arsize", {29'd0, bus.arsize}, 32'd2);
          check("arid", {28'd0, bus.arid}, 32'd0);
          check("arburst", {30'd0, bus.arburst}, 32'd1);
        end
      end
      if (bus.rvalid && bus.rready && bus.rid == 4'd0) begin
        beats++;
        if (bus.rlast) rlast_cyc = cyc;
      end
    end
  end

  task automatic expect_ar(input logic [31:0] a, input logic [7:0] l);
    exp_araddr.push_back(a);
    exp_arlen.push_back(l);
  endtask

  task automatic send(input logic [19:0] t, input logic [7:0] i, input logic [3:0] o,
                      output int waits, output int acc_cyc);
    bus.inst_valid  = 1'b1;
    bus.inst_tag    = t;
    bus.inst_index  = i;
    bus.inst_offset = o;
    waits = 0;
    acc_cyc = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.inst_addr_ok) break;
      waits++;
    end
    if (waits >= 300) check("addr_ok_timeout", 32'd0, 32'd1);
    acc_cyc = cyc + 1;
    @(posedge clk); #1;
  endtask

  task automatic idle_bus();
    bus.inst_valid = 1'b0;
  endtask

  task automatic fetch(input logic [19:0] t, input logic [7:0] i, input logic [3:0] o,
                       input logic [31:0] exp_data);
    int w, a;
    exp_q.push_back(exp_data);
    send(t, i, o, w, a);
    idle_bus();
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0 && exp_araddr.size() == 0) break;
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_data", exp_q.size(), 32'd0);
    check("drain_ar", exp_araddr.size(), 32'd0);
  endtask

  initial begin : main
    int w, a, a0, b0;
    cyc = 0; n_tests = 0; n_fail = 0; beats = 0; rlast_cyc = 0; last_exp = '0;
    bad_rid_en = 1'b0; early_last_en = 1'b0;
    bus.inst_valid = 1'b0; bus.inst_op = 1'b0;
    bus.inst_tag = '0; bus.inst_index = '0; bus.inst_offset = '0;
    mem[32'h0000_0000] = 32'h11; mem[32'h0000_0004] = 32'h22;
    mem[32'h0000_0008] = 32'h33; mem[32'h0000_000C] = 32'h44;
    mem[32'h1FC0_0000] = 32'h3C1C_BFC0;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_addr_ok", {31'd0, bus.inst_addr_ok}, 32'd0);
    check("rst_data_ok", {31'd0, bus.inst_data_ok}, 32'd0);
    check("rst_rdata", bus.inst_rdata, 32'd0);
    check("rst_arvalid", {31'd0, bus.arvalid}, 32'd0);
    check("rst_rready", {31'd0, bus.rready}, 32'd0);
`ifdef ICACHE_PERF_CNT_EN
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;

    // 1: cold miss, critical word is word 1
    expect_ar(32'h0000_0000, 8'd3);
    okq.delete();
    fetch(20'h80000, 8'h00, 4'h4, 32'h22);
    drain();
    check("miss_latency", okq.size() > 0 ? okq[0] : 0, rlast_cyc + 1);
    check("rdata_hold", bus.inst_rdata, last_exp);

    // 2: four back-to-back hits
    okq.delete();
    exp_q.push_back(32'h11); exp_q.push_back(32'h22);
    exp_q.push_back(32'h33); exp_q.push_back(32'h44);
    send(20'h80000, 8'h00, 4'h0, w, a0);
    send(20'h80000, 8'h00, 4'h4, w, a); check("b2b_wait1", w, 0);
    send(20'h80000, 8'h00, 4'h8, w, a); check("b2b_wait2", w, 0);
    send(20'h80000, 8'h00, 4'hC, w, a); check("b2b_wait3", w, 0);
    idle_bus();
    drain();
    check("hit_count", okq.size(), 4);
    if (okq.size() == 4) begin
      check("hit_latency", okq[0], a0);
      for (int k = 0; k < 3; k++) check("hit_streak", okq[k+1] - okq[k], 1);
    end
`ifdef ICACHE_PERF_CNT_EN
    check("perf_hit", hit_cnt, 32'd4);
    check("perf_miss", miss_cnt, 32'd1);
`endif

    // 3: uncached, repeated fetch goes to the bus again
    expect_ar(32'h1FC0_0000, 8'd0);
    fetch(20'hBFC00, 8'h00, 4'h0, 32'h3C1C_BFC0);
    drain();
    mem[32'h1FC0_0000] = 32'h2408_0001;
    expect_ar(32'h1FC0_0000, 8'd0);
    fetch(20'hBFC00, 8'h00, 4'h0, 32'h2408_0001);
    drain();
`ifdef ICACHE_PERF_CNT_EN
    check("perf_miss_unc", miss_cnt, 32'd1);
`endif

    // 4: conflict eviction of set 0
    expect_ar(32'h0000_1000, 8'd3);
    fetch(20'h80001, 8'h00, 4'h8, mem_word(32'h0000_1008));
    drain();
    expect_ar(32'h0000_0000, 8'd3);
    fetch(20'h80000, 8'h00, 4'hC, 32'h44);
    drain();

    // foreign-rid beat in the middle of a refill is skipped
    bad_rid_en = 1'b1;
    expect_ar(32'h0000_2050, 8'd3);
    fetch(20'h80002, 8'h05, 4'h8, mem_word(32'h0000_2058));
    drain();
    bad_rid_en = 1'b0;
    fetch(20'h80002, 8'h05, 4'hC, mem_word(32'h0000_205C));
    fetch(20'h80002, 8'h05, 4'h4, mem_word(32'h0000_2054));
    drain();

    // early rlast after two beats: partial line still installed
    early_last_en = 1'b1;
    expect_ar(32'h0000_3070, 8'd3);
    fetch(20'h80003, 8'h07, 4'h4, mem_word(32'h0000_3074));
    drain();
    early_last_en = 1'b0;
    fetch(20'h80003, 8'h07, 4'h0, mem_word(32'h0000_3070));
    drain();

    // 5: reset in the middle of a refill
    expect_ar(32'h0000_4100, 8'd3);
    b0 = beats;
    send(20'h80004, 8'h10, 4'h0, w, a);
    idle_bus();
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #2;
      if (beats >= b0 + 2) break;
    end
    check("refill_progress", (beats >= b0 + 2) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_arvalid", {31'd0, bus.arvalid}, 32'd0);
    check("mid_rst_rready", {31'd0, bus.rready}, 32'd0);
    check("mid_rst_data_ok", {31'd0, bus.inst_data_ok}, 32'd0);
    check("mid_rst_rdata", bus.inst_rdata, 32'd0);
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("post_rst_ar_q", exp_araddr.size(), 32'd0);
    expect_ar(32'h0000_4100, 8'd3);
    fetch(20'h80004, 8'h10, 4'h0, mem_word(32'h0000_4100));
    drain();
    // set 0 was also invalidated by reset
    expect_ar(32'h0000_0000, 8'd3);
    fetch(20'h80000, 8'h00, 4'h8, 32'h33);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
